// File: rtl/aes_encrypt_rounds.sv
// ---------------------------------------------------------------------------
// aes_encrypt_rounds
//   Iterative AES-128 encryption datapath. It takes the 44-word round-key bus
//   from key_expansion and encrypts one 128-bit block at a time, doing one
//   full round per clock. A block is accepted in cycle 0, rounds run in cycles
//   1..NR, and the ciphertext is presented from cycle NR+1 until the consumer
//   takes it. Blocks do not overlap.
//
// Ports
//   clk         in   1            rising-edge clock
//   rst_n       in   1            synchronous active-low reset
//   w_in        in   128*(NR+1)   round-key words; word i = w_in[i*32+31 -: 32]
//   in_valid    in   1            plain_in valid
//   in_ready    out  1            high only while idle
//   plain_in    in   128          plaintext, byte k = plain_in[k*8+7 -: 8]
//   out_valid   out  1            cipher_out valid
//   out_ready   in   1            consumer takes cipher_out
//   cipher_out  out  128          ciphertext, byte k = cipher_out[k*8+7 -: 8]
//   busy        out  1            high while rounds run or result is pending
//
// Byte k of the state is row k%4, column k/4. Round key r byte 4c+j is
// word (4r+c) bits [31-8j -: 8]. w_in is not latched; it must be held stable
// from the accept cycle through the last round.
// ---------------------------------------------------------------------------
module aes_encrypt_rounds #(
  parameter int NR = 10  // only 10 (AES-128) is meaningful
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [128*(NR+1)-1:0]   w_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            plain_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            cipher_out,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(NR);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t           r_state, w_state_next;
  logic [15:0][7:0] r_st, w_st_next;
  logic [3:0]       r_rnd, w_rnd_next;

  // Round-key bus viewed as NR+1 128-bit round keys.
  logic [NR:0][127:0] w_keys;
  logic [127:0]       w_rk_cur;
  logic [15:0][7:0]   w_rk_b;     // current round key in state byte order
  logic [15:0][7:0]   w_rk0_b;    // initial whitening key in state byte order
  logic [15:0][7:0]   w_sb;       // after SubBytes
  logic [15:0][7:0]   w_sr;       // after ShiftRows
  logic [15:0][7:0]   w_mc;       // after MixColumns
  logic [15:0][7:0]   w_round_out;

  assign w_keys   = w_in;
  assign w_rk_cur = w_keys[r_rnd];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      // Byte j of a word sits at the MSB end, so row 0 comes from bits [31:24].
      assign w_rk_b[gi]  = w_rk_cur[COL*32 + 24 - 8*ROW +: 8];
      assign w_rk0_b[gi] = w_keys[0][COL*32 + 24 - 8*ROW +: 8];
      assign w_sb[gi]    = SBOX[r_st[gi]];
      // Row r rotates left by r columns.
      assign w_sr[gi]    = w_sb[ROW + 4*((COL + ROW) % 4)];
    end

    for (gi = 0; gi < 4; gi++) begin : g_col
      logic [7:0] w_a0, w_a1, w_a2, w_a3;
      assign w_a0 = w_sr[4*gi + 0];
      assign w_a1 = w_sr[4*gi + 1];
      assign w_a2 = w_sr[4*gi + 2];
      assign w_a3 = w_sr[4*gi + 3];
      // 3*x is written as xtime(x) ^ x.
      assign w_mc[4*gi + 0] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
      assign w_mc[4*gi + 1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
      assign w_mc[4*gi + 2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
      assign w_mc[4*gi + 3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end
  endgenerate

  // The final round skips MixColumns.
  assign w_round_out = (r_rnd == LAST_RND) ? (w_sr ^ w_rk_b) : (w_mc ^ w_rk_b);

  always_comb begin
    w_state_next = r_state;
    w_st_next    = r_st;
    w_rnd_next   = r_rnd;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_st_next    = plain_in ^ w_rk0_b;
          w_rnd_next   = 4'd1;
          w_state_next = S_ROUND;
        end
      end
      S_ROUND: begin
        busy      = 1'b1;
        w_st_next = w_round_out;
        if (r_rnd == LAST_RND) begin
          w_state_next = S_DONE;
        end else begin
          w_rnd_next = r_rnd + 4'd1;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_st    <= '0;
      r_rnd   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_st    <= w_st_next;
      r_rnd   <= w_rnd_next;
    end
  end

  assign cipher_out = r_st;

endmodule

// File: tb/tb_aes_encrypt_rounds.sv
// ---------------------------------------------------------------------------
// tb_aes_encrypt_rounds
//   Directed bench for aes_encrypt_rounds using the FIPS-197 C.1 and App.B
//   vectors. The round-key bus is produced by a small key-expansion model
//   in the bench; ciphertexts are the published constants.
// ---------------------------------------------------------------------------
module tb_aes_encrypt_rounds;

  localparam logic [127:0] K1  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PT1 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CT1 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] K2  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] PT2 = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] CT2 = 128'h320b6a19978511dcfb09dc021d842539;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic          clk;
  logic          rst_n;
  logic [1407:0] w_in;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  plain_in;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  cipher_out;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  aes_encrypt_rounds #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_in       (w_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plain_in   (plain_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cipher_out (cipher_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Standard AES-128 key schedule; word 0 holds key bytes 0..3 with byte 0 at the MSB.
  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      w[i] = {key[32*i +: 8], key[32*i+8 +: 8], key[32*i+16 +: 8], key[32*i+24 +: 8]};
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one block from IDLE and wait for its result (bounded). With junk set,
  // in_valid toggles with a different plaintext while the block is in flight.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] ct,
                           input string tag, input bit junk);
    int n;
    check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    plain_in = pt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, 128'(busy && !in_ready), 128'd1);
    n = 1;
    while (!out_valid && n < 40) begin
      if (junk) begin
        in_valid = ~in_valid;
        plain_in = ~pt;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 128'(n), 128'd11);
    check({tag, "_ct"}, cipher_out, ct);
    $display("block %s pt=%h ct=%h latency=%0d", tag, pt, cipher_out, n);
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ret_in_ready"}, 128'(in_ready), 128'd1);
    check({tag, "_ret_out_valid"}, 128'(out_valid), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pts [3];
    logic [127:0] cts [3];
    logic [127:0] keys [3];
    int acc [3];
    int ni;
    int no;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plain_in  = '0;
    w_in      = expand(K1);
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_cipher", cipher_out, 128'd0);

    // FIPS-197 C.1
    run_block(PT1, CT1, "c1", 1'b0);
    retire("c1");

    // FIPS-197 App.B, then backpressure while holding the result
    w_in = expand(K2);
    run_block(PT2, CT2, "appb", 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("bp_out_valid_%0d", i), 128'(out_valid), 128'd1);
      check($sformatf("bp_ct_%0d", i), cipher_out, CT2);
    end
    retire("bp");

    // Inputs offered while busy are ignored
    w_in = expand(K1);
    run_block(PT1, CT1, "busyin", 1'b1);
    retire("busyin");
    run_block(PT1, CT1, "after_busy", 1'b0);
    retire("after_busy");

    // Reset in the middle of a block (round 5)
    plain_in = PT1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_cipher", cipher_out, 128'd0);
    repeat (15) tick();
    check("midrst_no_output", 128'(out_valid), 128'd0);
    run_block(PT1, CT1, "post_rst", 1'b0);
    retire("post_rst");

    // Back-to-back with in_valid and out_ready held high
    pts[0] = PT1; cts[0] = CT1; keys[0] = K1;
    pts[1] = PT2; cts[1] = CT2; keys[1] = K2;
    pts[2] = PT1; cts[2] = CT1; keys[2] = K1;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    ni = 0;
    no = 0;
    w_in      = expand(keys[0]);
    plain_in  = pts[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 80 && no < 3; c++) begin
      if (in_ready && in_valid && ni < 3) begin
        acc[ni] = c;
        ni++;
      end
      if (out_valid) begin
        check($sformatf("b2b_ct_%0d", no), cipher_out, cts[no]);
        $display("block b2b_%0d ct=%h accepted_at=%0d", no, cipher_out, acc[no]);
        no++;
        // The DUT is in DONE here, so switching keys now cannot touch a block in flight.
        if (no < 3) begin
          w_in     = expand(keys[no]);
          plain_in = pts[no];
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_outputs", 128'(no), 128'd3);
    check("b2b_gap_01", 128'(acc[1] - acc[0]), 128'd12);
    check("b2b_gap_12", 128'(acc[2] - acc[1]), 128'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
